// File: rtl/adc_axis_packetizer.sv
// adc_axis_packetizer
// ADC front end: divides the stream clock down to the ADC conversion clock,
// captures one sample (or a test ramp) per conversion, frames the samples
// into packets and streams them out of a small FIFO as an AXI4-Stream master.
// Stop requests finish the current packet before the block returns to idle.

module adc_axis_packetizer #(
  parameter int ADC_WIDTH              = 14,
  parameter int C_M00_AXIS_TDATA_WIDTH = 16,
  parameter int CLK_DIV                = 4,
  parameter int FIFO_DEPTH             = 16
) (
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_areset,
  output logic                                  adc_clk,
  input  logic [ADC_WIDTH-1:0]                  adc_data,
  input  logic                                  adc_otr,
  input  logic [3:0]                            control,
  input  logic [15:0]                           pkt_len,
  output logic [31:0]                           status,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready
);

  localparam int TDW  = C_M00_AXIS_TDATA_WIDTH;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int DIVW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLK_DIV / 2);

  // One FIFO entry: the stream word plus its packet-end marker.
  typedef struct packed {
    logic           last;
    logic [TDW-1:0] data;
  } fifo_word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DRAIN
  } state_t;

  // Control decode
  logic stream_enable, clear_overrun, clear_otr, test_mode;
  assign stream_enable = control[0];
  assign clear_overrun = control[1];
  assign clear_otr     = control[2];
  assign test_mode     = control[3];

  state_t               state;
  logic [DIVW-1:0]      div;
  logic [ADC_WIDTH-1:0] ramp;
  logic [15:0]          idx;
  logic [15:0]          pkt_len_q;

  logic [AW:0]          wr_ptr, rd_ptr;
  fifo_word_t           mem [FIFO_DEPTH];
  fifo_word_t           rd_word, cap_word;

  logic                 ovr_sticky, otr_sticky;
  logic [15:0]          ovr_count;

  logic capturing, div_last, flush_stop, strobe;
  logic cap_otr, cap_last;
  logic [ADC_WIDTH-1:0] cap_data;
  logic fifo_empty, fifo_full, pop, push, drop;

  // Capture timing: one strobe per divider period while capturing. Once a
  // stop has been requested and we are sitting on a packet boundary, the
  // strobe is suppressed so no sample of a new packet leaks out.
  assign capturing  = (state == S_RUN) || (state == S_FLUSH);
  assign div_last   = (div == DIV_LAST);
  assign flush_stop = (state == S_FLUSH) && ((pkt_len_q == 16'd0) || (idx == 16'd0));
  assign strobe     = capturing && div_last && !flush_stop;

  // Conversion clock decoded from the divider flops: high for the first half.
  assign adc_clk = capturing && (div < DIV_HALF);

  // Sample selection and word assembly
  assign cap_otr  = test_mode ? 1'b0 : adc_otr;
  assign cap_data = test_mode ? ramp : adc_data;
  assign cap_last = (pkt_len_q != 16'd0) && (idx == pkt_len_q - 16'd1);

  // Build the stored word: sample in the low bits, OTR in the MSB, rest zero.
  always_comb begin
    cap_word                     = '0;
    cap_word.last                = cap_last;
    cap_word.data[ADC_WIDTH-1:0] = cap_data;
    cap_word.data[TDW-1]         = cap_otr;
  end

  // FIFO status; pointers carry one wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && m00_axis_tready;
  // A full FIFO still takes the sample when a word leaves in the same cycle.
  assign push       = strobe && (!fifo_full || pop);
  assign drop       = strobe && fifo_full && !pop;

  // Sequencer: divider, ramp, packet index and run/flush/drain state.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state     <= S_IDLE;
      div       <= '0;
      ramp      <= '0;
      idx       <= '0;
      pkt_len_q <= '0;
    end else begin
      // Dropped samples still step the ramp and index so framing is kept.
      if (strobe) begin
        ramp <= ramp + 1'b1;
        idx  <= cap_last ? 16'd0 : idx + 16'd1;
      end
      case (state)
        S_IDLE: begin
          div <= '0;
          if (stream_enable) begin
            state     <= S_RUN;
            idx       <= '0;
            ramp      <= '0;
            pkt_len_q <= pkt_len;
          end
        end
        S_RUN: begin
          div <= div_last ? '0 : div + 1'b1;
          if (!stream_enable) state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (flush_stop || (strobe && cap_last)) begin
            state <= S_DRAIN;
            div   <= '0;
          end else begin
            div <= div_last ? '0 : div + 1'b1;
          end
        end
        S_DRAIN: begin
          div <= '0;
          if (fifo_empty) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          div   <= '0;
        end
      endcase
    end
  end

  // FIFO pointers; reset discards any buffered words.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge m00_axis_aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cap_word;
  end

  assign rd_word = mem[rd_ptr[AW-1:0]];

  // Sticky flags and overrun counter; a clear beats a same-cycle set.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      ovr_sticky <= 1'b0;
      ovr_count  <= '0;
      otr_sticky <= 1'b0;
    end else begin
      if (clear_overrun) begin
        ovr_sticky <= 1'b0;
        ovr_count  <= '0;
      end else if (drop) begin
        ovr_sticky <= 1'b1;
        if (ovr_count != 16'hFFFF) ovr_count <= ovr_count + 16'd1;
      end
      if (clear_otr)             otr_sticky <= 1'b0;
      else if (strobe && cap_otr) otr_sticky <= 1'b1;
    end
  end

  // Stream outputs: head of FIFO, forced to zero when nothing is buffered.
  assign m00_axis_tvalid = !fifo_empty;
  assign m00_axis_tdata  = fifo_empty ? '0 : rd_word.data;
  assign m00_axis_tlast  = !fifo_empty && rd_word.last;
  assign m00_axis_tstrb  = '1;

  // Status built only from flops, so it trails its cause by one cycle.
  assign status = {ovr_count, 12'd0, fifo_full, otr_sticky, ovr_sticky,
                   (state != S_IDLE)};

endmodule
